// File: rtl/ratio_mult_path_pkg.sv
// ratio_mult_path_pkg
// Shared widths, iteration count and divider state encoding for the
// ratio_mult_path datapath slice.
package ratio_mult_path_pkg;

    localparam int DW       = 26;  // dividend / quotient width
    localparam int SW       = 14;  // divisor width
    localparam int MW       = 13;  // multiplier coefficient width
    localparam int PW       = 10;  // s2p word width
    localparam int ITER_CNT = 26;  // one quotient bit per RUN cycle
    localparam int ICNT_W   = 5;   // holds 0..ITER_CNT-1
    localparam int PCNT_W   = 4;   // holds 0..PW-1

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/ratio_mult_path_s2p_shift.sv
// s2p_shift
// Serial-to-parallel converter: shifts one bit per enabled clock, MSB
// first, and presents each completed PW-bit word with a one-cycle pulse.
// Ports:
//   clk, rst     clock, async active-high reset
//   en           shift enable; low freezes counter and partial word
//   dext         serial input bit
//   dout         last assembled word
//   dout_valid   one-cycle pulse when dout updates
module s2p_shift
    import ratio_mult_path_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          dext,
    output logic [PW-1:0] dout,
    output logic          dout_valid
);

    logic [PW-1:0]     sr;
    logic [PCNT_W-1:0] cnt;
    logic [PW-1:0]     sr_next;

    assign sr_next = {sr[PW-2:0], dext};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (en) begin
                sr <= sr_next;
                if (cnt == PCNT_W'(PW - 1)) begin
                    cnt        <= '0;
                    dout       <= sr_next;
                    dout_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ratio_mult_path.sv
// ratio_mult_path
// Restoring divider (DW / SW bits, one quotient bit per cycle), a
// registered quotient*coefficient multiplier and an independent
// serial-to-parallel converter.
// Ports:
//   clk, rst     clock, async active-high reset
//   en           starts/continues division, enables s2p shifting
//   dividend     unsigned dividend, sampled at capture
//   divisor      unsigned divisor, sampled at capture
//   quotient     last completed quotient
//   divider_ok   one-cycle pulse when quotient updates
//   multi2       unsigned multiplier coefficient
//   product      registered quotient*multi2 (zero until first completion)
//   dext         serial input bit
//   dout         last assembled s2p word
//   dout_valid   one-cycle pulse when dout updates
//   div_zero     (only with DIV_ZERO_FLAG_EN) captured divisor was zero
// Build option: define DIV_ZERO_FLAG_EN to add the div_zero output.
module ratio_mult_path
    import ratio_mult_path_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DW-1:0]    dividend,
    input  logic [SW-1:0]    divisor,
    output logic [DW-1:0]    quotient,
    output logic             divider_ok,
    input  logic [MW-1:0]    multi2,
    output logic [DW+MW-1:0] product,
    input  logic             dext,
    output logic [PW-1:0]    dout,
    output logic             dout_valid
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    div_state_t          state;
    logic [DW-1:0]       dvd_sr;   // dividend bits shift out, quotient bits shift in
    logic [SW-1:0]       dvs;
    logic [SW-1:0]       rem;
    logic [ICNT_W-1:0]   iter;
    logic                mul_armed;

    logic [SW:0]         rem_sh;
    logic [SW:0]         rem_diff;
    logic                q_bit;
    logic [DW-1:0]       q_next;
    logic                unused_diff_msb;

    // Trial subtraction; with divisor 0 every bit is 1, giving all ones.
    assign rem_sh          = {rem, dvd_sr[DW-1]};
    assign q_bit           = (rem_sh >= {1'b0, dvs});
    assign rem_diff        = rem_sh - {1'b0, dvs};
    assign q_next          = {dvd_sr[DW-2:0], q_bit};
    // After a successful subtraction the remainder is below the divisor,
    // so the top difference bit never carries information.
    assign unused_diff_msb = rem_diff[SW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dvd_sr     <= '0;
            dvs        <= '0;
            rem        <= '0;
            iter       <= '0;
            quotient   <= '0;
            divider_ok <= 1'b0;
            mul_armed  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero   <= 1'b0;
`endif
        end else begin
            divider_ok <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (en) begin
                        dvd_sr <= dividend;
                        dvs    <= divisor;
                        rem    <= '0;
                        iter   <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    dvd_sr <= q_next;
                    rem    <= q_bit ? rem_diff[SW-1:0] : rem_sh[SW-1:0];
                    iter   <= iter + 1'b1;
                    if (iter == ICNT_W'(ITER_CNT - 1)) begin
                        quotient   <= q_next;
                        divider_ok <= 1'b1;
                        mul_armed  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero   <= (dvs == '0);
`endif
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else if (mul_armed) begin
            product <= {{MW{1'b0}}, quotient} * {{DW{1'b0}}, multi2};
        end else begin
            product <= '0;
        end
    end

    s2p_shift u_s2p (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dext       (dext),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

endmodule

// File: tb/tb_ratio_mult_path.sv
module tb_ratio_mult_path;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [25:0] dividend;
    logic [13:0] divisor;
    logic [25:0] quotient;
    logic        divider_ok;
    logic [12:0] multi2;
    logic [38:0] product;
    logic        dext;
    logic [9:0]  dout;
    logic        dout_valid;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    always #5 clk = ~clk;

    ratio_mult_path dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .divider_ok (divider_ok),
        .multi2     (multi2),
        .product    (product),
        .dext       (dext),
        .dout       (dout),
        .dout_valid (dout_valid)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero   (div_zero)
`endif
    );

    typedef struct {
        logic [25:0] q;
        logic [38:0] p;
        logic        z;
    } div_exp_t;

    div_exp_t    dq[$];
    logic [9:0]  sq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_words = 0;
    bit          div_chk = 0;
    bit          s2p_chk = 0;
    bit          prod_pend = 0;
    logic [38:0] prod_exp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Divider / multiplier monitor
    always @(negedge clk) begin
        if (prod_pend) chk("product", 64'(product), 64'(prod_exp));
        prod_pend = 0;
        if (div_chk && divider_ok) begin
            if (dq.size() == 0) begin
                chk("unexpected_divider_ok", 64'(1), 64'(0));
            end else begin
                div_exp_t e;
                e = dq.pop_front();
                chk("quotient", 64'(quotient), 64'(e.q));
`ifdef DIV_ZERO_FLAG_EN
                chk("div_zero", 64'(div_zero), 64'(e.z));
`endif
                prod_exp  = e.p;
                prod_pend = 1;
            end
        end
    end

    // s2p monitor
    always @(negedge clk) begin
        if (s2p_chk && dout_valid) begin
            n_words++;
            if (sq.size() == 0) chk("unexpected_dout_valid", 64'(1), 64'(0));
            else chk("dout", 64'(dout), 64'(sq.pop_front()));
        end
    end

    // Called at the negedge right after the capture edge; counts edges
    // until divider_ok is seen.
    task automatic measure(output int k);
        k = 0;
        while (!divider_ok && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    task automatic push_div(input logic [25:0] q, input logic [38:0] p, input logic z);
        div_exp_t e;
        e.q = q; e.p = p; e.z = z;
        dq.push_back(e);
    endtask

    task automatic run_div(input logic [25:0] a, input logic [13:0] b, input logic [12:0] m,
                           input logic [25:0] q, input logic [38:0] p, input logic z, input string nm);
        int k;
        @(negedge clk);
        dividend = a; divisor = b; multi2 = m; en = 1;
        push_div(q, p, z);
        @(posedge clk);
        @(negedge clk);
        en = 0;
        measure(k);
        chk(nm, 64'(k), 64'(26));
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        en = 1; dext = b;
    endtask

    initial begin
        int k;
        rst = 1; en = 0; dividend = 0; divisor = 0; multi2 = 0; dext = 0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", 64'(quotient), 64'(0));
        chk("rst_divider_ok", 64'(divider_ok), 64'(0));
        chk("rst_product", 64'(product), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_dout_valid", 64'(dout_valid), 64'(0));
        rst = 0;
        @(negedge clk);

        // 1638400/300 twice back to back, en dropped and operands changed mid-RUN
        div_chk = 1;
        dividend = 26'd1638400; divisor = 14'd300; multi2 = 13'd4096; en = 1;
        push_div(26'd5461, 39'd22368256, 1'b0);
        push_div(26'd5461, 39'd22368256, 1'b0);
        @(posedge clk);
        @(negedge clk);
        measure(k);
        chk("first_latency", 64'(k), 64'(26));
        chk("product_before_arm", 64'(product), 64'(0));
        @(posedge clk);
        @(negedge clk);
        en = 0; dividend = 26'hFFF; divisor = 14'd7;
        measure(k);
        chk("period_27", 64'(k), 64'(26));
        @(negedge clk);

        run_div(26'd12345, 14'd0, 13'd4096, 26'h3FFFFFF, 39'd274877902848, 1'b1, "div0_latency");
        run_div(26'h3FFFFFF, 14'd1, 13'h1FFF, 26'h3FFFFFF, 39'd549688696833, 1'b0, "max_latency");
        run_div(26'd1000, 14'd7, 13'd3, 26'd142, 39'd426, 1'b0, "small_latency");
        run_div(26'd5, 14'd300, 13'd77, 26'd0, 39'd0, 1'b0, "zero_q_latency");

        // Reset in the middle of RUN with en held high
        @(negedge clk);
        dividend = 26'd1638400; divisor = 14'd300; multi2 = 13'd4096; en = 1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_quotient", 64'(quotient), 64'(0));
        chk("midrst_divider_ok", 64'(divider_ok), 64'(0));
        chk("midrst_product", 64'(product), 64'(0));
        chk("midrst_dout", 64'(dout), 64'(0));
        @(negedge clk);
        rst = 0;
        push_div(26'd5461, 39'd22368256, 1'b0);
        @(posedge clk);
        @(negedge clk);
        en = 0;
        chk("rearm_product_zero", 64'(product), 64'(0));
        measure(k);
        chk("restart_latency", 64'(k), 64'(26));
        repeat (2) @(negedge clk);
        chk("div_queue_empty", 64'(dq.size()), 64'(0));

        // s2p from a clean reset
        @(negedge clk);
        rst = 1; en = 0;
        @(negedge clk);
        rst = 0; div_chk = 0; s2p_chk = 1;
        sq.push_back(10'h2CD);
        sq.push_back(10'h1C6);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        send_bit(0); send_bit(1); send_bit(1); send_bit(0); send_bit(1);
        send_bit(0); send_bit(1); send_bit(1); send_bit(1); send_bit(0);
        @(negedge clk); en = 0; dext = 1;
        @(negedge clk); dext = 0;
        @(negedge clk); dext = 1;
        send_bit(0); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        @(negedge clk); en = 0;
        repeat (3) @(negedge clk);
        chk("s2p_words", 64'(n_words), 64'(2));
        chk("s2p_queue_empty", 64'(sq.size()), 64'(0));
        chk("dout_held", 64'(dout), 64'(10'h1C6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ratio_mult_path.md
Name: ratio_mult_path

Overview:
- Arithmetic datapath core combining three functions:
  - Iterative unsigned divider: 26-bit dividend / 14-bit divisor.
  - Registered unsigned multiplier: quotient x 13-bit coefficient.
  - Independent 10-bit serial-to-parallel converter for a 1-bit external stream.
- Sits between input register stage and sine lookup/sign-correction logic of the normalisation top level.

Parameters:
- DW, 26, dividend and quotient width
- SW, 14, divisor width
- MW, 13, multiplier coefficient width (product width DW+MW = 39)
- PW, 10, s2p word width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  enables divider iteration and s2p shifting
- dividend  in  26  unsigned dividend, sampled at operand capture
- divisor  in  14  unsigned divisor, sampled at operand capture
- quotient  out  26  last completed quotient, held between completions
- divider_ok  out  1  one-cycle pulse when quotient updates
- multi2  in  13  unsigned multiplier coefficient
- product  out  39  registered quotient*multi2
- dext  in  1  serial input bit
- dout  out  10  last assembled s2p word
- dout_valid  out  1  one-cycle pulse when dout updates

Behaviour:
- Reset (async, rst=1): all outputs 0, divider state IDLE, mul_armed=0, s2p counter 0, shift register 0.
- Divider FSM states:
  - IDLE: if en, capture dividend/divisor on the edge, clear remainder, iteration count=0 -> RUN.
  - RUN: restoring division, one quotient bit per cycle, MSB first; remainder width SW+1. After the 26th iteration edge -> DONE; quotient register loads result, divider_ok=1.
  - DONE: lasts one cycle. If en, capture new operands -> RUN; else -> IDLE. divider_ok returns to 0.
- Divider timing:
  - Capture at edge N; divider_ok high after edge N+26, low after N+27.
  - Back-to-back period 27 cycles while en held high.
- Divider boundary conditions:
  - en dropping during RUN does not abort; the operation completes.
  - Operand changes during RUN are ignored.
  - divisor=0 -> quotient=all ones (0x3FFFFFF), divider_ok still pulses.
- Multiplier:
  - mul_armed is sticky: set on first divider_ok, cleared only by rst.
  - While armed, product <= quotient*multi2 every clock (full 39-bit unsigned, no truncation); 1-cycle latency from quotient/multi2 change.
  - Unarmed: product holds 0.
- s2p:
  - Each clock with en=1, shift register <= {sr[8:0], dext} (first bit ends as MSB); counter increments.
  - On the 10th bit: dout <= assembled word, dout_valid=1 for one cycle, counter wraps to 0.
  - en=0 freezes counter and shift register; the partial word is retained.
- Reset mid-operation discards in-progress division and partial s2p word.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined: extra output div_zero (1 bit), valid with divider_ok, high when the captured divisor was 0; held until next divider_ok; reset 0.
- Undefined: port absent; divide-by-zero behaviour otherwise identical.

Decomposition:
- Shared package:
  - width constants DW, SW, MW, PW
  - divider state enum {IDLE, RUN, DONE}
  - ITER_CNT=26 constant
- One natural sub-module: s2p_shift (counter + shift register + valid pulse). Divider and multiplier stay in the top body.

Test Plan:
- Reset: assert rst mid-RUN with en=1 -> quotient=0, divider_ok=0, product=0, dout=0 immediately; operation restarts after release.
- Division: dividend=100<<14 (1638400), divisor=300, en=1 -> divider_ok pulses 26 edges after capture, quotient=5461; repeats every 27 cycles.
- Multiply: after the above with multi2=4096 -> product=22368256 one cycle after quotient update; product=0 before first divider_ok.
- Divide by zero and max: divisor=0 -> quotient=0x3FFFFFF. Dividend=0x3FFFFFF, divisor=1, multi2=0x1FFF -> quotient=0x3FFFFFF, product=549688696833.
- s2p: feed 1,0,1,1,0,0,1,1,0,1 with en=1 -> dout=0x2CD with one-cycle dout_valid on the 10th edge. Deassert en for 3 cycles mid-word -> word still assembles correctly.
- DIV_ZERO_FLAG_EN build: divisor=0 -> div_zero=1 with divider_ok; next nonzero divisor -> div_zero=0.
